// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron blocks.
//
// Contents:
//   CURRENT_W         width of the signed summed synaptic current
//   VMEM_W_DEFAULT    default signed membrane-potential width
//   REFRAC_W_DEFAULT  default refractory counter width
//   neuron_state_e    neuron FSM states (INTEGRATE, REFRACTORY)
package snn_pkg;

  localparam int unsigned CURRENT_W        = 5;
  localparam int unsigned VMEM_W_DEFAULT   = 8;
  localparam int unsigned REFRAC_W_DEFAULT = 4;

  typedef enum logic {
    INTEGRATE  = 1'b0,
    REFRACTORY = 1'b1
  } neuron_state_e;

endpackage

// File: rtl/snn_sat_addsub.sv
// Saturating signed adder/subtractor.
//
// Computes y = a + b (sub = 0) or y = a - b (sub = 1) on W-bit two's-complement
// operands, clamping the result to [-2^(W-1), 2^(W-1)-1] instead of wrapping.
//
// Ports:
//   a    in   W  signed left operand
//   b    in   W  signed right operand
//   sub  in   1  0: add, 1: subtract
//   y    out  W  saturated signed result
module snn_sat_addsub #(
  parameter int unsigned W = 8
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic                sub,
  output logic signed [W-1:0] y
);

  localparam logic signed [W-1:0] MaxVal = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MinVal = {1'b1, {(W-1){1'b0}}};

  logic signed [W:0] a_ext;
  logic signed [W:0] b_ext;
  logic signed [W:0] full;

  always_comb begin
    a_ext = {a[W-1], a};
    b_ext = {b[W-1], b};
    full  = sub ? (a_ext - b_ext) : (a_ext + b_ext);
    // One guard bit is enough: overflow shows up as the top two bits disagreeing,
    // and the guard bit carries the true sign of the result.
    if (full[W] != full[W-1]) begin
      y = full[W] ? MinVal : MaxVal;
    end else begin
      y = full[W-1:0];
    end
  end

endmodule

// File: rtl/spike_neuron_lif.sv
// Leaky integrate-and-fire neuron.
//
// On each enabled timestep the neuron adds the signed synaptic current to its
// membrane potential (saturating), fires when the sum reaches the threshold, and
// otherwise leaks the potential toward zero by a fixed magnitude. After a spike
// it ignores input for refractory_period timesteps.
//
// Optional feature: define SNN_NEURON_SPIKE_COUNT_EN to add a saturating 8-bit
// spike counter output (spike_count).
//
// Ports:
//   clk                 in   1          rising-edge clock
//   reset               in   1          synchronous active-high reset, dominant
//   enable              in   1          timestep strobe
//   input_current       in   5          signed summed synaptic current
//   threshold           in   VMEM_W-1   unsigned firing threshold
//   leak                in   VMEM_W-1   unsigned per-step leak magnitude
//   refractory_period   in   REFRAC_W   timesteps ignored after a spike
//   spike_out           out  1          registered one-cycle spike pulse
//   membrane_potential  out  VMEM_W     registered signed potential
//   refractory          out  1          high while refractory
//   spike_count         out  8          saturating spike count (optional)
module spike_neuron_lif
  import snn_pkg::*;
#(
  parameter int unsigned VMEM_W   = VMEM_W_DEFAULT,
  parameter int unsigned REFRAC_W = REFRAC_W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic signed [CURRENT_W-1:0] input_current,
  input  logic        [VMEM_W-2:0]   threshold,
  input  logic        [VMEM_W-2:0]   leak,
  input  logic        [REFRAC_W-1:0] refractory_period,
  output logic                       spike_out,
  output logic signed [VMEM_W-1:0]   membrane_potential,
  output logic                       refractory
`ifdef SNN_NEURON_SPIKE_COUNT_EN
  ,
  output logic        [7:0]          spike_count
`endif
);

  localparam logic [REFRAC_W-1:0] CntOne = {{(REFRAC_W-1){1'b0}}, 1'b1};

  neuron_state_e             state_q, state_d;
  logic signed [VMEM_W-1:0]  v_q, v_d;
  logic [REFRAC_W-1:0]       cnt_q, cnt_d;
  logic                      spike_q, spike_d;

  logic signed [VMEM_W-1:0]  cur_ext;
  logic signed [VMEM_W-1:0]  thr_ext;
  logic signed [VMEM_W-1:0]  leak_ext;
  logic signed [VMEM_W-1:0]  neg_leak;
  logic signed [VMEM_W-1:0]  sum;
  logic signed [VMEM_W-1:0]  leaked;
  logic                      leak_sub;

  // Threshold and leak are magnitudes; a zero top bit keeps them non-negative
  // so the signed compares below behave.
  assign cur_ext  = {{(VMEM_W-CURRENT_W){input_current[CURRENT_W-1]}}, input_current};
  assign thr_ext  = {1'b0, threshold};
  assign leak_ext = {1'b0, leak};
  assign neg_leak = -leak_ext;

  snn_sat_addsub #(
    .W (VMEM_W)
  ) u_integrate (
    .a   (v_q),
    .b   (cur_ext),
    .sub (1'b0),
    .y   (sum)
  );

  // Leak pulls toward zero: subtract for positive sums, add for negative ones.
  assign leak_sub = (sum > leak_ext);

  snn_sat_addsub #(
    .W (VMEM_W)
  ) u_leak (
    .a   (sum),
    .b   (leak_ext),
    .sub (leak_sub),
    .y   (leaked)
  );

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    spike_d = 1'b0;

    if (enable) begin
      unique case (state_q)
        INTEGRATE: begin
          if (sum >= thr_ext) begin
            spike_d = 1'b1;
            v_d     = '0;
            if (refractory_period != '0) begin
              cnt_d   = refractory_period;
              state_d = REFRACTORY;
            end
          end else if ((sum > leak_ext) || (sum < neg_leak)) begin
            v_d = leaked;
          end else begin
            v_d = '0;
          end
        end
        REFRACTORY: begin
          v_d = '0;
          // The step that takes the counter from 1 to 0 is the last ignored one.
          if (cnt_q <= CntOne) begin
            cnt_d   = '0;
            state_d = INTEGRATE;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        default: begin
          state_d = INTEGRATE;
          cnt_d   = '0;
          v_d     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INTEGRATE;
      v_q     <= '0;
      cnt_q   <= '0;
      spike_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      spike_q <= spike_d;
    end
  end

  assign spike_out          = spike_q;
  assign membrane_potential = v_q;
  assign refractory         = (state_q == REFRACTORY);

`ifdef SNN_NEURON_SPIKE_COUNT_EN
  logic [7:0] spike_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      spike_cnt_q <= '0;
    end else if (spike_d && (spike_cnt_q != 8'hFF)) begin
      spike_cnt_q <= spike_cnt_q + 8'd1;
    end
  end

  assign spike_count = spike_cnt_q;
`endif

endmodule

// File: tb/tb_spike_neuron_lif.sv
// Self-checking bench for spike_neuron_lif (default VMEM_W=8, REFRAC_W=4).
// Directed scenarios followed by randomized timesteps, all compared against a
// behavioural model that tracks the potential and remaining ignored steps as
// plain integers.
module tb_spike_neuron_lif;

  localparam int VW   = 8;
  localparam int RW   = 4;
  localparam int VMAX = 127;
  localparam int VMIN = -128;

  logic              clk;
  logic              reset;
  logic              enable;
  logic signed [4:0] input_current;
  logic [VW-2:0]     threshold;
  logic [VW-2:0]     leak;
  logic [RW-1:0]     refractory_period;
  logic              spike_out;
  logic signed [VW-1:0] membrane_potential;
  logic              refractory;
`ifdef SNN_NEURON_SPIKE_COUNT_EN
  logic [7:0]        spike_count;
`endif

  spike_neuron_lif #(
    .VMEM_W   (VW),
    .REFRAC_W (RW)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (enable),
    .input_current      (input_current),
    .threshold          (threshold),
    .leak               (leak),
    .refractory_period  (refractory_period),
    .spike_out          (spike_out),
    .membrane_potential (membrane_potential),
    .refractory         (refractory)
`ifdef SNN_NEURON_SPIKE_COUNT_EN
    ,
    .spike_count        (spike_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int m_v    = 0;
  int m_rem  = 0;  // ignored timesteps still to come
  int m_spk  = 0;
  int m_scnt = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit en, input int cur, input int thr,
                            input int lk, input int rp);
    int s;
    if (rst) begin
      m_v = 0; m_rem = 0; m_spk = 0; m_scnt = 0;
    end else if (!en) begin
      m_spk = 0;
    end else if (m_rem > 0) begin
      m_rem--; m_v = 0; m_spk = 0;
    end else begin
      s = m_v + cur;
      if (s > VMAX) s = VMAX;
      if (s < VMIN) s = VMIN;
      if (s >= thr) begin
        m_spk = 1; m_v = 0; m_rem = rp;
        if (m_scnt < 255) m_scnt++;
      end else begin
        m_spk = 0;
        if (s > lk)       m_v = s - lk;
        else if (s < -lk) m_v = s + lk;
        else              m_v = 0;
      end
    end
  endtask

  // Apply one timestep, let it be sampled, then compare all outputs to the model.
  task automatic do_step(input bit rst, input bit en, input int cur, input int thr,
                         input int lk, input int rp);
    int vm;
    reset             = rst;
    enable            = en;
    input_current     = cur[4:0];
    threshold         = thr[VW-2:0];
    leak              = lk[VW-2:0];
    refractory_period = rp[RW-1:0];
    @(posedge clk);
    #1;
    model_step(rst, en, cur, thr, lk, rp);
    vm = membrane_potential;
    check("spike_out", int'(spike_out), m_spk);
    check("membrane_potential", vm, m_v);
    check("refractory", int'(refractory), (m_rem > 0) ? 1 : 0);
`ifdef SNN_NEURON_SPIKE_COUNT_EN
    check("spike_count", int'(spike_count), m_scnt);
`endif
  endtask

  function automatic int vnow();
    int vm;
    vm = membrane_potential;
    return vm;
  endfunction

  initial begin
    int exp_v [7];
    int exp_s [7];
    int cur, thr, lk, rp;
    bit rst, en;

    reset = 1'b1; enable = 1'b0; input_current = '0;
    threshold = '0; leak = '0; refractory_period = '0;

    // Reset dominates enable with a large positive current.
    do_step(1, 1, 15, 10, 0, 2);
    do_step(1, 1, 15, 10, 0, 2);
    check("reset_v", vnow(), 0);
    check("reset_spike", int'(spike_out), 0);
    check("reset_refractory", int'(refractory), 0);

    // Fire and refractory: +3 per step, threshold 10, period 2.
    exp_v = '{3, 6, 9, 0, 0, 0, 3};
    exp_s = '{0, 0, 0, 1, 0, 0, 0};
    for (int i = 0; i < 7; i++) begin
      do_step(0, 1, 3, 10, 0, 2);
      check($sformatf("fire_v_step%0d", i + 1), vnow(), exp_v[i]);
      check($sformatf("fire_spike_step%0d", i + 1), int'(spike_out), exp_s[i]);
    end

    // Leak: one +5 step then zero current with leak 2.
    do_step(1, 0, 0, 0, 0, 0);
    exp_v = '{3, 1, 0, 0, 0, 0, 0};
    for (int i = 0; i < 4; i++) begin
      do_step(0, 1, (i == 0) ? 5 : 0, 127, 2, 0);
      check($sformatf("leak_v_step%0d", i + 1), vnow(), exp_v[i]);
    end

    // Saturation at the negative rail.
    do_step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) do_step(0, 1, -16, 127, 0, 0);
    check("sat_v_min", vnow(), -128);

    // Hold with enable low during refractory, then reset mid-refractory.
    do_step(1, 0, 0, 0, 0, 0);
    do_step(0, 1, 3, 2, 0, 5);
    check("hold_spike", int'(spike_out), 1);
    for (int i = 0; i < 3; i++) do_step(0, 0, 15, 2, 0, 5);
    check("hold_refractory", int'(refractory), 1);
    check("hold_spike_low", int'(spike_out), 0);
    do_step(1, 0, 0, 10, 0, 5);
    check("midref_reset_refractory", int'(refractory), 0);
    do_step(0, 1, 3, 10, 0, 5);
    check("after_reset_integrates", vnow(), 3);

    // Threshold zero with no refractory period: fires on every non-negative sum.
    do_step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) do_step(0, 1, 0, 0, 0, 0);
    check("thr0_fire", int'(spike_out), 1);
    do_step(0, 1, -1, 0, 0, 0);
    check("thr0_negative_no_fire", int'(spike_out), 0);

`ifdef SNN_NEURON_SPIKE_COUNT_EN
    do_step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) do_step(0, 1, 0, 0, 0, 0);
    check("spike_count_3", int'(spike_count), 3);
    for (int i = 0; i < 297; i++) do_step(0, 1, 0, 0, 0, 0);
    check("spike_count_sat", int'(spike_count), 255);
`endif

    // Randomized timesteps.
    do_step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      en  = ($urandom_range(0, 3) != 0);
      cur = int'($urandom_range(0, 31)) - 16;
      thr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 127))
                                        : int'($urandom_range(0, 30));
      lk  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127))
                                        : int'($urandom_range(0, 4));
      rp  = int'($urandom_range(0, 15));
      do_step(rst, en, cur, thr, lk, rp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_neuron_lif.md
SPIKE_NEURON_LIF -- requirements
Module: spike_neuron_lif

Interface
REQ-001 The block SHALL have parameter VMEM_W, default 8, giving the signed membrane potential width (minimum 6).
REQ-002 The block SHALL have parameter REFRAC_W, default 4, giving the refractory counter width.
REQ-003 The block SHALL have a single clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high; dominates every other input.
REQ-006 enable  input  1  timestep strobe; state advances only on edges where it is high.
REQ-007 input_current  input  5  signed two's-complement summed synaptic current (-16..+15).
REQ-008 threshold  input  VMEM_W-1  unsigned firing threshold, zero-extended to VMEM_W.
REQ-009 leak  input  VMEM_W-1  unsigned per-timestep leak magnitude.
REQ-010 refractory_period  input  REFRAC_W  number of timesteps ignored after a spike.
REQ-011 spike_out  output  1  registered single-cycle spike pulse.
REQ-012 membrane_potential  output  VMEM_W  registered signed potential v.
REQ-013 refractory  output  1  high while in REFRACTORY.

Function
REQ-014 The block SHALL implement states INTEGRATE and REFRACTORY.
REQ-015 With enable low, the block SHALL hold v, state and counter, and drive spike_out low on the next edge.
REQ-016 In INTEGRATE with enable high, the block SHALL compute sum = v + sign-extended input_current, saturated to [-2^(VMEM_W-1), 2^(VMEM_W-1)-1].
REQ-017 If sum >= threshold (signed compare), the block SHALL set spike_out=1 for one cycle and v=0.
REQ-018 On a spike, it SHALL load the counter with refractory_period and enter REFRACTORY if refractory_period != 0; otherwise it SHALL remain in INTEGRATE.
REQ-019 Without a spike, the block SHALL set v = sum-leak if sum > leak, sum+leak if sum < -leak, else 0.
REQ-020 In REFRACTORY with enable high, the block SHALL ignore input_current, hold v=0 and decrement the counter.
REQ-021 It SHALL return to INTEGRATE on the enabled edge where the counter is decremented from 1 to 0, so exactly refractory_period timesteps are ignored.
REQ-022 With threshold=0, the block SHALL fire on every integrating step where sum >= 0.
REQ-023 Update latency SHALL be one clock: outputs reflect an enabled step on the edge that samples it.

Reset
REQ-024 On a reset edge, the block SHALL set v=0, spike_out=0, counter=0 and state=INTEGRATE (refractory=0), regardless of enable or current state.

Configuration
REQ-025 When SNN_NEURON_SPIKE_COUNT_EN is defined, the block SHALL add output spike_count [7:0], incremented on each spike, saturating at 255 and cleared by reset.
REQ-026 When SNN_NEURON_SPIKE_COUNT_EN is undefined, the spike_count port and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-027 Shared package snn_pkg SHALL hold the state enum (INTEGRATE, REFRACTORY), the current width constant (5) and the default VMEM_W and REFRAC_W.
REQ-028 Saturating signed add/subtract SHALL be a single sub-module, snn_sat_addsub, instantiated for the integrate and leak steps.

Verification
REQ-029 Reset: assert reset with enable=1 and input_current=+15 -> v=0, spike_out=0, refractory=0.
REQ-030 Fire/refractory: input_current=+3, threshold=10, leak=0, refractory_period=2, enable every cycle -> v=3,6,9; spike on step 4 with v=0; steps 5-6 ignored; step 7 v=3.
REQ-031 Leak: leak=2, one step input +5 then 0 -> v=3,1,0,0.
REQ-032 Saturation: input_current=-16 repeatedly, leak=0 -> v reaches -128 and holds without wrap.
REQ-033 Hold/reset mid-refractory: enable low holds all state; reset during REFRACTORY -> state INTEGRATE, v=0, counter=0.
REQ-034 Macro: with SNN_NEURON_SPIKE_COUNT_EN defined, 3 spikes -> spike_count=3; 300 spikes -> spike_count=255.
